// File: rtl/timer_pkg.sv
// Shared types for the multi-window timer: channel modes, channel FSM states
// and the decode of the raw 2-bit mode field.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_RETRIG   = 2'd1,
        MODE_PERIODIC = 2'd2
    } mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // The unused encoding 3 folds onto ONESHOT so the latched mode is always legal.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_RETRIG;
            2'd2:    return MODE_PERIODIC;
            default: return MODE_ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: measures a window against the shared timebase using
// modulo subtraction, so a timebase wrap inside a window needs no special case.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CTR_WIDTH = 22,
    parameter int DUR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 ce,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CTR_WIDTH-1:0] ctr,
    input  logic [DUR_WIDTH-1:0] duration,
    input  logic [1:0]           mode_sel,
    output state_t               state,
    output logic                 done
);

    logic [CTR_WIDTH-1:0] snap;
    logic [DUR_WIDTH-1:0] dur;
    mode_t                mode;
    logic [CTR_WIDTH-1:0] elapsed;
    logic                 expired;

    assign elapsed = ctr - snap;
    assign expired = (elapsed >= CTR_WIDTH'(dur));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            snap  <= '0;
            dur   <= '0;
            mode  <= MODE_ONESHOT;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ce) begin
                if (abort) begin
                    state <= IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            if (start) begin
                                if (duration != '0) begin
                                    snap  <= ctr;
                                    dur   <= duration;
                                    mode  <= decode_mode(mode_sel);
                                    state <= COUNT;
                                end else begin
                                    // Zero-length window: expire at once, never open.
                                    done <= 1'b1;
                                end
                            end
                        end
                        COUNT: begin
                            // A retrigger on the expiry edge wins and suppresses done.
                            if (mode == MODE_RETRIG && start) begin
                                snap <= ctr;
                                dur  <= duration;
                            end else if (expired) begin
                                done <= 1'b1;
                                if (mode == MODE_PERIODIC) begin
                                    snap <= snap + CTR_WIDTH'(dur);
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/multi_window_timer.sv
// N_CH independent window timers sharing one free-running timebase; the top
// only slices the packed per-channel buses and reduces the busy flag.
module multi_window_timer
    import timer_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CTR_WIDTH = 22,
    parameter int DUR_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_nrst,
    input  logic                      i_ce,
    input  logic [CTR_WIDTH-1:0]      i_ctr,
    input  logic [N_CH-1:0]           i_start,
    input  logic [N_CH-1:0]           i_abort,
    input  logic [N_CH*DUR_WIDTH-1:0] i_duration,
    input  logic [2*N_CH-1:0]         i_mode,
    output logic [N_CH-1:0]           o_active,
    output logic [N_CH-1:0]           o_done,
    output logic                      o_busy
);

    state_t [N_CH-1:0] ch_state;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        timer_channel #(
            .CTR_WIDTH(CTR_WIDTH),
            .DUR_WIDTH(DUR_WIDTH)
        ) u_ch (
            .clk      (i_clk),
            .nrst     (i_nrst),
            .ce       (i_ce),
            .start    (i_start[k]),
            .abort    (i_abort[k]),
            .ctr      (i_ctr),
            .duration (i_duration[k*DUR_WIDTH +: DUR_WIDTH]),
            .mode_sel (i_mode[2*k +: 2]),
            .state    (ch_state[k]),
            .done     (o_done[k])
        );

        // Decoded straight from the state register, so no input reaches o_active.
        assign o_active[k] = (ch_state[k] == COUNT);
    end

    assign o_busy = |o_active;

endmodule

// File: tb/tb_multi_window_timer.sv
// Directed bench for multi_window_timer: one-shot, timebase wrap, retrigger,
// periodic with clock-enable gaps, simultaneous channels and async reset.
module tb_multi_window_timer;

    localparam int N_CH      = 4;
    localparam int CTR_WIDTH = 22;
    localparam int DUR_WIDTH = 16;

    logic                      i_clk;
    logic                      i_nrst;
    logic                      i_ce;
    logic [CTR_WIDTH-1:0]      i_ctr;
    logic [N_CH-1:0]           i_start;
    logic [N_CH-1:0]           i_abort;
    logic [N_CH*DUR_WIDTH-1:0] i_duration;
    logic [2*N_CH-1:0]         i_mode;
    logic [N_CH-1:0]           o_active;
    logic [N_CH-1:0]           o_done;
    logic                      o_busy;

    int errors = 0;
    int checks = 0;

    multi_window_timer #(
        .N_CH(N_CH),
        .CTR_WIDTH(CTR_WIDTH),
        .DUR_WIDTH(DUR_WIDTH)
    ) dut (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_ce       (i_ce),
        .i_ctr      (i_ctr),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_duration (i_duration),
        .i_mode     (i_mode),
        .o_active   (o_active),
        .o_done     (o_done),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: the edge samples the current inputs, then the timebase
    // advances if that edge was enabled. Returns at posedge+1.
    task automatic cyc();
        @(posedge i_clk);
        #1;
        if (i_ce) i_ctr = i_ctr + 1'b1;
    endtask

    // Check channel ch before each of n clocks: window state and no done pulse.
    task automatic run_n(input string tag, input int n, input int ch, input logic exp_act);
        for (int i = 0; i < n; i++) begin
            check({tag, "_act"}, 32'(o_active[ch]), 32'(exp_act));
            check({tag, "_done0"}, 32'(o_done[ch]), 32'd0);
            cyc();
        end
    endtask

    task automatic set_ch(input int ch, input logic [DUR_WIDTH-1:0] d, input logic [1:0] m);
        i_duration[ch*DUR_WIDTH +: DUR_WIDTH] = d;
        i_mode[2*ch +: 2] = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_nrst     = 1'b0;
        i_ce       = 1'b0;
        i_ctr      = '0;
        i_start    = '0;
        i_abort    = '0;
        i_duration = '0;
        i_mode     = '0;
        #1;
        check("rst_active", 32'(o_active), 32'd0);
        check("rst_done",   32'(o_done),   32'd0);
        check("rst_busy",   32'(o_busy),   32'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_nrst = 1'b1;
        @(posedge i_clk);
        #1;
        i_ce = 1'b1;

        // One-shot, D=5 started at 100: open for 101..105, done seen at 106.
        i_ctr = 22'd100;
        set_ch(0, 16'd5, 2'd0);
        i_start = 4'b0001;
        cyc();
        i_start = '0;
        run_n("oneshot", 5, 0, 1'b1);
        check("oneshot_end_act",  32'(o_active[0]), 32'd0);
        check("oneshot_end_done", 32'(o_done[0]),   32'd1);
        cyc();
        check("oneshot_post_done", 32'(o_done[0]), 32'd0);

        // Window straddling the timebase wrap.
        i_ctr = 22'h3FFFFE;
        set_ch(0, 16'd4, 2'd0);
        i_start = 4'b0001;
        cyc();
        i_start = '0;
        run_n("wrap", 4, 0, 1'b1);
        check("wrap_end_act",  32'(o_active[0]), 32'd0);
        check("wrap_end_done", 32'(o_done[0]),   32'd1);
        check("wrap_ctr_seen", 32'(i_ctr),       32'd3);

        // Retrigger at elapsed 6, then again exactly on the expiry edge.
        i_ctr = 22'd200;
        set_ch(1, 16'd8, 2'd1);
        i_start = 4'b0010;
        cyc();
        i_start = '0;
        run_n("retrig_a", 5, 1, 1'b1);
        i_start = 4'b0010;
        run_n("retrig_r1", 1, 1, 1'b1);
        i_start = '0;
        run_n("retrig_b", 7, 1, 1'b1);
        i_start = 4'b0010;
        run_n("retrig_r2", 1, 1, 1'b1);
        i_start = '0;
        run_n("retrig_c", 8, 1, 1'b1);
        check("retrig_end_act",  32'(o_active[1]), 32'd0);
        check("retrig_end_done", 32'(o_done[1]),   32'd1);

        // Periodic D=3 for 10 periods with random enable gaps, then abort.
        i_ctr = 22'd300;
        set_ch(2, 16'd3, 2'd2);
        i_start = 4'b0100;
        cyc();
        i_start = '0;
        for (int k = 1; k <= 30; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                i_ce = 1'b0;
                cyc();
                check("per_gap_act",  32'(o_active[2]), 32'd1);
                check("per_gap_done", 32'(o_done[2]),   32'd0);
            end
            i_ce = 1'b1;
            cyc();
            check("per_act",  32'(o_active[2]), 32'd1);
            check("per_done", 32'(o_done[2]),   32'((k % 3) == 0));
        end
        i_abort = 4'b0100;
        cyc();
        i_abort = '0;
        check("per_abort_act",  32'(o_active[2]), 32'd0);
        check("per_abort_done", 32'(o_done[2]),   32'd0);
        cyc();
        check("per_abort_done2", 32'(o_done[2]), 32'd0);

        // Four channels on one edge with D=1,2,3,0.
        i_ctr = 22'd500;
        set_ch(0, 16'd1, 2'd0);
        set_ch(1, 16'd2, 2'd0);
        set_ch(2, 16'd3, 2'd0);
        set_ch(3, 16'd0, 2'd0);
        i_start = 4'b1111;
        cyc();
        i_start = '0;
        check("multi_t0_act",  32'(o_active), 32'b0111);
        check("multi_t0_done", 32'(o_done),   32'b1000);
        check("multi_t0_busy", 32'(o_busy),   32'd1);
        cyc();
        check("multi_t1_act",  32'(o_active), 32'b0110);
        check("multi_t1_done", 32'(o_done),   32'b0001);
        cyc();
        check("multi_t2_act",  32'(o_active), 32'b0100);
        check("multi_t2_done", 32'(o_done),   32'b0010);
        check("multi_t2_busy", 32'(o_busy),   32'd1);
        cyc();
        check("multi_t3_act",  32'(o_active), 32'b0000);
        check("multi_t3_done", 32'(o_done),   32'b0100);
        check("multi_t3_busy", 32'(o_busy),   32'd0);
        cyc();
        check("multi_t4_done", 32'(o_done), 32'b0000);

        // Asynchronous reset mid-window, off the clock edge.
        i_ctr = 22'd600;
        set_ch(0, 16'd10, 2'd0);
        i_start = 4'b0001;
        cyc();
        i_start = '0;
        run_n("arst_pre", 3, 0, 1'b1);
        #2;
        i_nrst = 1'b0;
        #1;
        check("arst_act",  32'(o_active), 32'd0);
        check("arst_busy", 32'(o_busy),   32'd0);
        check("arst_done", 32'(o_done),   32'd0);
        @(posedge i_clk);
        #4;
        i_nrst = 1'b1;
        cyc();
        run_n("arst_post", 12, 0, 1'b0);

        // Mode 3 behaves as one-shot and ignores a start while counting.
        i_ctr = 22'd700;
        set_ch(0, 16'd4, 2'd3);
        i_start = 4'b0001;
        cyc();
        i_start = '0;
        run_n("m3_a", 1, 0, 1'b1);
        set_ch(0, 16'd9, 2'd3);
        i_start = 4'b0001;
        run_n("m3_ign", 1, 0, 1'b1);
        i_start = '0;
        run_n("m3_b", 2, 0, 1'b1);
        check("m3_end_act",  32'(o_active[0]), 32'd0);
        check("m3_end_done", 32'(o_done[0]),   32'd1);

        // Abort beats a zero-length start in IDLE: no done.
        set_ch(3, 16'd0, 2'd0);
        i_start = 4'b1000;
        i_abort = 4'b1000;
        cyc();
        i_start = '0;
        i_abort = '0;
        check("abort_idle_done", 32'(o_done[3]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_window_timer.md
MULTI_WINDOW_TIMER -- requirements
Module: multi_window_timer

Interface
REQ-001 Parameter N_CH, default 4: number of independent timer channels, range 1..16.
REQ-002 Parameter CTR_WIDTH, default 22: width of the shared timebase counter.
REQ-003 Parameter DUR_WIDTH, default 16: width of each channel duration, DUR_WIDTH <= CTR_WIDTH.
REQ-004 i_clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 i_nrst  input  1  reset; asynchronous, active-low.
REQ-006 i_ce  input  1  clock enable; channel state advances only on edges where i_ce=1.
REQ-007 i_ctr  input  CTR_WIDTH  free-running shared timebase, treated as modulo 2^CTR_WIDTH.
REQ-008 i_start  input  N_CH  per-channel start request, bit k -> channel k.
REQ-009 i_abort  input  N_CH  per-channel abort request.
REQ-010 i_duration  input  N_CH*DUR_WIDTH  per-channel window length in timebase ticks, channel k at slice [k*DUR_WIDTH +: DUR_WIDTH].
REQ-011 i_mode  input  2*N_CH  per-channel mode: 0 ONESHOT, 1 RETRIG, 2 PERIODIC; 3 behaves as ONESHOT.
REQ-012 o_active  output  N_CH  channel window open.
REQ-013 o_done  output  N_CH  one-cycle pulse on window expiry.
REQ-014 o_busy  output  1  OR of all o_active bits.

Function
REQ-015 Each channel shall have states IDLE and COUNT, with latched registers snap (CTR_WIDTH), dur (DUR_WIDTH) and mode (2).
REQ-016 Elapsed time shall be computed as (i_ctr - snap) modulo 2^CTR_WIDTH, so a timebase wrap mid-window is handled transparently.
REQ-017 IDLE, i_ce=1, i_start[k]=1, duration != 0: latch snap<=i_ctr, dur and mode from the inputs, then go to COUNT.
REQ-018 IDLE, start with duration 0: stay IDLE, pulse o_done[k] on the next cycle, keep o_active[k] low.
REQ-019 COUNT, i_ce=1, elapsed >= dur: ONESHOT/RETRIG go to IDLE; PERIODIC sets snap<=snap+dur (modulo) and stays in COUNT; every mode pulses o_done[k].
REQ-020 RETRIG in COUNT with i_start: reload snap<=i_ctr and dur; start beats a same-edge expiry, and no o_done is produced for that edge.
REQ-021 ONESHOT/PERIODIC in COUNT: ignore i_start.
REQ-022 i_abort[k] with i_ce=1: force IDLE, no o_done; abort has priority over start and expiry on the same edge.
REQ-023 o_active[k] shall equal (state==COUNT) and be driven from a register, with no combinational path from the inputs.
REQ-024 o_done[k] shall be registered: high for exactly one i_clk cycle, in the cycle after the expiry edge.
REQ-025 With i_ctr incrementing by 1 per i_ce cycle, a start accepted at i_ctr=c shall hold o_active high while i_ctr = c+1 .. c+D, which is exactly D ce-cycles.
REQ-026 i_ce=0: hold all state; o_done still clears after one cycle.
REQ-027 Channels shall be fully independent; simultaneous events on different channels shall not interact.

Reset
REQ-028 i_nrst=0 shall asynchronously force every channel to IDLE and clear snap, dur, mode, o_active, o_done and o_busy.
REQ-029 Reset mid-window shall discard the window without an o_done pulse.
REQ-030 Reset deassertion shall be synchronised externally; the block shall act on the first edge after release.

Structure
REQ-031 Package timer_pkg shall hold the mode enum (MODE_ONESHOT, MODE_RETRIG, MODE_PERIODIC) and the state enum (IDLE, COUNT).
REQ-032 Sub-module timer_channel shall implement one channel and be instantiated N_CH times by generate; the top holds only slicing and the o_busy reduction.

Verification
REQ-033 ONESHOT, ch0, D=5, start at i_ctr=100 -> o_active high while i_ctr=101..105; o_done pulse at i_ctr=106; then IDLE.
REQ-034 Wrap: CTR_WIDTH=22, start at i_ctr=0x3FFFFE, D=4 -> active for 4 ticks across the wrap; o_done when i_ctr=0x000002 has been sampled.
REQ-035 RETRIG, D=8, restart at elapsed 6, and a second restart on the exact expiry edge -> window extended both times, no o_done until 8 ticks after the last start.
REQ-036 PERIODIC, D=3, run 10 periods with random i_ce gaps -> o_done every 3 ticks, no drift, o_active continuously high; abort -> low, no final o_done.
REQ-037 All 4 channels started on the same edge with D=1,2,3,0 -> independent o_done pulses at +1,+2,+3 ticks and immediately for D=0; o_busy tracks the OR of o_active.
REQ-038 Assert i_nrst=0 asynchronously mid-window (not clock-aligned) -> outputs 0 immediately, no o_done after release.
